pipe_skid_buffer_128: RTL
=========================

// Module: pipe_skid_buffer_128
// PURPOSE
//   Two-entry valid/ready skid buffer that feeds a 128-bit pipeline stage register.
//   It decouples the upstream stage's ready path from downstream backpressure:
//   - in_ready is a registered output, so it has no combinational path from out_ready.
//   - Full throughput is sustained.
//   Sync flush drops in-flight entries (branch/exception squash) and counts them.
// PARAMETERS
//   WIDTH     128   payload width in bits
//   CNT_W     8     width of drop counter (saturating)
// PORTS
//   clk          in   1      rising-edge clock
//   areset_n     in   1      async active-low reset
//   in_valid     in   1      upstream payload valid
//   in_ready     out  1      buffer can accept (registered)
//   in_data      in   WIDTH  upstream payload
//   out_valid    out  1      out_data valid (registered)
//   out_ready    in   1      downstream stage accepts (its write_enable)
//   out_data     out  WIDTH  payload to stage register (registered)
//   flush        in   1      sync squash of all held entries
//   occupancy    out  2      entries held: 0, 1 or 2
//   drop_cnt     out  CNT_W  entries discarded by flush, saturating
// BEHAVIOUR
//   Storage: main reg (drives out_data) + skid reg. State EMPTY/ONE/TWO = occupancy 0/1/2.
//   Reset (areset_n low, async):
//     - state EMPTY, out_valid=0, in_ready=0, out_data=0, skid=0, occupancy=0, drop_cnt=0.
//     - in_ready rises at the first clk edge after areset_n deasserts.
//   Transfers:
//     - in_xfer  = in_valid & in_ready
//     - out_xfer = out_valid & out_ready
//     - Both are evaluated on the same edge.
//   Transitions (flush=0):
//     EMPTY: in_xfer -> main<=in_data, ONE; else stay.
//     ONE:   in_xfer&out_xfer -> main<=in_data, ONE
//            in_xfer only     -> skid<=in_data, TWO
//            out_xfer only    -> EMPTY
//     TWO:   in_ready=0 (no in_xfer); out_xfer -> main<=skid, ONE; else hold.
//   Ordering and latency:
//     - Strict FIFO order; no payload is duplicated or lost without flush.
//     - Latency in_xfer -> out_valid is 1 cycle when EMPTY.
//   in_ready next = (next_state != TWO).
//     - Asserted in EMPTY and ONE, deasserted only in TWO.
//   Flush (highest priority over all transfers):
//     - Next state EMPTY; any in_xfer in the same cycle is dropped.
//     - drop_cnt += occupancy + in_xfer, saturating at 2^CNT_W-1.
//     - Data regs may keep stale values; out_valid=0 masks them.
//   While out_valid=1 and out_ready=0, out_data must be stable.
//   drop_cnt never wraps; it is cleared only by reset.
//   Reset mid-operation: all entries are lost immediately; no drop_cnt update.
// TESTING
//   1 Reset release:
//     in_ready=0 during reset, 1 one edge after release.
//     out_valid=0, drop_cnt=0.
//   2 Streaming, out_ready=1, in_data=0..9 back-to-back:
//     out_data=0..9 on consecutive cycles, lag 1.
//     occupancy stays 1, in_ready stays 1.
//   3 Backpressure, out_ready=0, push A then B:
//     occupancy=2, in_ready=0, out_data=A.
//     Raise out_ready: A then B emitted, in_ready=1 after A leaves.
//   4 Flush in TWO with in_valid=1:
//     Next cycle out_valid=0, occupancy=0, drop_cnt=2.
//     The new input is not dropped, since in_ready=0.
//   5 Flush in ONE with in_xfer:
//     drop_cnt+=2. Preload drop_cnt=254, flush 2 entries -> drop_cnt=255 (saturated).
//   6 Random valid/ready, 10k cycles, scoreboard:
//     Output sequence equals input sequence.
//     No transfer while in_ready=0; out_data stable under stall.

Source files
------------

// File: rtl/pipe_skid_buffer_128.sv
// Two-entry valid/ready skid buffer in front of a WIDTH-bit stage register.
// in_ready, out_valid and out_data are all registered; flush squashes held entries and counts them.
module pipe_skid_buffer_128 #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]     drop_sum;
  logic               in_xfer;
  logic               out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(state_q) + (CNT_W+1)'(in_xfer);

    if (flush) begin
      // Flush outranks every transfer; data regs keep stale contents, out_valid masks them.
      state_d = EMPTY;
      if (drop_sum[CNT_W]) drop_cnt_d = '1;
      else                 drop_cnt_d = drop_sum[CNT_W-1:0];
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
